// File: rtl/uart_frame_pkg.sv
//------------------------------------------------------------------------------
// Module   : uart_frame_pkg
// Brief    : Shared types, default header bytes and CRC-16/CCITT-FALSE helper
//            for the UART frame transmitter.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR0  = 3'd1,
        ST_HDR1  = 3'd2,
        ST_LEN   = 3'd3,
        ST_PLD   = 3'd4,
        ST_CHK_H = 3'd5,
        ST_CHK_L = 3'd6,
        ST_WAIT  = 3'd7
    } state_e;

    localparam logic [7:0]  SYNC0_DEFAULT = 8'hEB;
    localparam logic [7:0]  SYNC1_DEFAULT = 8'h90;
    localparam logic [15:0] CRC16_POLY    = 16'h1021;
    localparam logic [15:0] CRC16_INIT    = 16'hFFFF;

    // MSB-first bytewise update, no reflection.
    function automatic logic [15:0] crc16_update(input logic [15:0] crc,
                                                 input logic [7:0]  data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_frame_fifo.sv
//------------------------------------------------------------------------------
// Module   : uart_frame_fifo
// Brief    : Synchronous first-word-fall-through byte FIFO with occupancy count.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_frame_fifo #(
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en_i,
    input  logic [7:0]               wr_data_i,
    input  logic                     rd_en_i,
    output logic [7:0]               rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_wr;
    logic          do_rd;

    assign full_o  = (count_q == FULL_LEVEL);
    assign empty_o = (count_q == '0);
    // A push into a full FIFO is dropped even when a pop happens in the same cycle.
    assign do_wr   = wr_en_i && !full_o;
    assign do_rd   = rd_en_i && !empty_o;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign level_o   = count_q;

endmodule

`default_nettype wire

// File: rtl/uart_frame_tx.sv
//------------------------------------------------------------------------------
// Module   : uart_frame_tx
// Brief    : Wraps FIFO payload as SYNC0 SYNC1 LEN payload checksum and drives
//            the byte-level UART transmit handshake. Define UART_FRAME_CRC16_EN
//            for a CRC-16/CCITT-FALSE trailer instead of the 8-bit sum.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_frame_tx
    import uart_frame_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter logic [7:0]  SYNC0 = SYNC0_DEFAULT,
    parameter logic [7:0]  SYNC1 = SYNC1_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             wr_data,
    input  logic                   wr_en,
    output logic                   full,
    output logic                   wr_ovf,
    output logic [$clog2(DEPTH):0] level,
    input  logic [7:0]             frame_len,
    input  logic                   frame_start,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   frame_err,
    output logic [7:0]             tx_data,
    output logic                   tx_data_ready,
    input  logic                   tx_status,
    input  logic                   tx_over
);

`ifdef UART_FRAME_CRC16_EN
    localparam int CHK_W = 16;
    localparam logic [CHK_W-1:0] CHK_INIT = CRC16_INIT;
    localparam state_e CHK_FIRST = ST_CHK_H;
`else
    localparam int CHK_W = 8;
    localparam logic [CHK_W-1:0] CHK_INIT = '0;
    localparam state_e CHK_FIRST = ST_CHK_L;
`endif

    state_e             state_q, state_d;
    state_e             ret_q, ret_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [CHK_W-1:0]   chk_q, chk_d;
    logic [7:0]         txd_q, txd_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               ovf_q;

    logic               emit;
    logic [7:0]         emit_byte;
    state_e             emit_next;
    logic               launch;
    logic               pop;
    logic [7:0]         fifo_rd_data;
    logic               fifo_full;
    logic               fifo_empty;
    logic [$clog2(DEPTH):0] fifo_level;
    logic               len_bad;

    uart_frame_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_data),
        .rd_en_i   (pop),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (fifo_level)
    );

    assign len_bad = (frame_len == 8'd0) || (9'(frame_len) > 9'(fifo_level));

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        cnt_d     = cnt_q;
        chk_d     = chk_q;
        txd_d     = txd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        emit      = 1'b0;
        emit_byte = txd_q;
        emit_next = state_q;
        pop       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    if (len_bad) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d   = frame_len;
                        chk_d   = CHK_INIT;
                        busy_d  = 1'b1;
                        state_d = ST_HDR0;
                    end
                end
            end
            ST_HDR0: begin
                emit      = 1'b1;
                emit_byte = SYNC0;
                emit_next = ST_HDR1;
            end
            ST_HDR1: begin
                emit      = 1'b1;
                emit_byte = SYNC1;
                emit_next = ST_LEN;
            end
            ST_LEN: begin
                // The counter still holds the latched length here.
                emit      = 1'b1;
                emit_byte = cnt_q;
                emit_next = ST_PLD;
            end
            ST_PLD: begin
                emit      = !fifo_empty;
                emit_byte = fifo_rd_data;
                emit_next = (cnt_q == 8'd1) ? CHK_FIRST : ST_PLD;
            end
            ST_CHK_H: begin
`ifdef UART_FRAME_CRC16_EN
                emit      = 1'b1;
                emit_byte = chk_q[15:8];
                emit_next = ST_CHK_L;
`else
                state_d   = ST_IDLE;
                busy_d    = 1'b0;
`endif
            end
            ST_CHK_L: begin
                emit      = 1'b1;
                emit_byte = chk_q[7:0];
                emit_next = ST_IDLE;
            end
            ST_WAIT: begin
                if (tx_over) begin
                    state_d = ret_q;
                    if (ret_q == ST_IDLE) begin
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        launch = emit && !tx_status;
        if (launch) begin
            txd_d   = emit_byte;
            ret_d   = emit_next;
            state_d = ST_WAIT;
            if (state_q == ST_PLD) begin
                pop   = 1'b1;
                cnt_d = cnt_q - 8'd1;
`ifdef UART_FRAME_CRC16_EN
                chk_d = crc16_update(chk_q, fifo_rd_data);
`else
                chk_d = chk_q + fifo_rd_data;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ret_q   <= ST_IDLE;
            cnt_q   <= 8'd0;
            chk_q   <= '0;
            txd_q   <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
            chk_q   <= chk_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ovf_q   <= wr_en && fifo_full;
        end
    end

    // The launch cycle presents the new byte; otherwise the in-flight byte is held.
    assign tx_data       = launch ? emit_byte : txd_q;
    assign tx_data_ready = launch;
    assign full          = fifo_full;
    assign level         = fifo_level;
    assign wr_ovf        = ovf_q;
    assign busy          = busy_q;
    assign frame_done    = done_q;
    assign frame_err     = err_q;

endmodule

`default_nettype wire
